core_list_scanner: RTL and testbench

//  AXI4-Lite read-only master; the initiator side of the core-list ROM slave.
//  On Start_EvtIn it walks the core list from BaseAddr_Gen and reads the 7 numeric words of each entry.

---
 rtl/core_list_scanner_pkg.sv | 47 ++++
 rtl/core_list_axi_read_master.sv | 45 ++++
 rtl/core_list_scanner.sv | 216 +++++++++++++++++++++
 tb/tb_core_list_scanner.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_list_scanner_pkg.sv
// Shared types and constants for the core-list scanner.
// The entry record holds the seven numeric words of one list entry.
package core_list_scanner_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_EMIT,
      ST_DONE
   } scan_state_e;

   typedef struct packed {
      logic [31:0] type_nr;
      logic [31:0] inst_nr;
      logic [31:0] version;
      logic [31:0] addr_low;
      logic [31:0] addr_high;
      logic [31:0] irq_mask;
      logic [31:0] sensitivity;
   } core_list_entry_t;

   localparam int WORDS_PER_ENTRY = 7;
   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   // Write one numeric word of an entry by its index within the entry
   function automatic core_list_entry_t entry_set_word(
      input core_list_entry_t e,
      input logic [2:0]       idx,
      input logic [31:0]      w
   );
      core_list_entry_t r;
      r = e;
      case (idx)
         3'd0: r.type_nr = w;
         3'd1: r.inst_nr = w;
         3'd2: r.version = w;
         3'd3: r.addr_low = w;
         3'd4: r.addr_high = w;
         3'd5: r.irq_mask = w;
         3'd6: r.sensitivity = w;
         default: r = e;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/core_list_axi_read_master.sv
// Single AR/R read transaction handshakes with a per-phase timeout.
// The scanner FSM requests a phase; this block acks it or times it out.
module core_list_axi_read_master #(
   parameter int TimeoutCycles_Gen = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic addr_req,
   input  logic data_req,
   output logic addr_ack,
   output logic data_ack,
   output logic timeout,
   output logic ar_valid,
   input  logic ar_ready,
   output logic r_ready,
   input  logic r_valid
);

   localparam int CW = $clog2(TimeoutCycles_Gen + 1);
   localparam logic [CW-1:0] LAST = CW'(TimeoutCycles_Gen - 1);

   logic [CW-1:0] wait_cnt;
   logic          active;
   logic          fire;

   assign ar_valid = addr_req;
   assign r_ready  = data_req;
   assign addr_ack = addr_req & ar_ready;
   assign data_ack = data_req & r_valid;
   assign active   = addr_req | data_req;
   assign fire     = addr_ack | data_ack;
   assign timeout  = active & ~fire & (wait_cnt == LAST);

   // Cycles spent waiting on the current phase; restarts on every phase entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (!active || fire || timeout) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/core_list_scanner.sv
// AXI4-Lite read master walking the core list and streaming each entry.
// Stops on terminator, entry limit, error response, timeout or overflow.
module core_list_scanner
   import core_list_scanner_pkg::*;
#(
   parameter logic [15:0] BaseAddr_Gen      = 16'h0000,
   parameter int          EntryStride_Gen   = 64,
   parameter int          MaxEntries_Gen    = 256,
   parameter int          TimeoutCycles_Gen = 1024,
   parameter int          ClockPeriod_Gen   = 20
) (
   input  logic        SysClk_ClkIn,
   input  logic        SysRstN_RstIn,
   input  logic        Start_EvtIn,
   output logic        Busy_DatOut,
   output logic        Done_DatOut,
   output logic        Error_DatOut,
   output logic [12:0] EntryCount_DatOut,
   output logic        EntryValid_ValOut,
   input  logic        EntryReady_RdyIn,
   output logic [31:0] EntryTypeNr_DatOut,
   output logic [31:0] EntryInstNr_DatOut,
   output logic [31:0] EntryVersion_DatOut,
   output logic [31:0] EntryAddrLow_DatOut,
   output logic [31:0] EntryAddrHigh_DatOut,
   output logic [31:0] EntryIrqMask_DatOut,
   output logic [31:0] EntrySensitivity_DatOut,
   output logic        AxiReadAddrValid_ValOut,
   input  logic        AxiReadAddrReady_RdyIn,
   output logic [15:0] AxiReadAddrAddress_AdrOut,
   output logic [2:0]  AxiReadAddrProt_DatOut,
   input  logic        AxiReadDataValid_ValIn,
   output logic        AxiReadDataReady_RdyOut,
   input  logic [1:0]  AxiReadDataResponse_DatIn,
   input  logic [31:0] AxiReadDataData_DatIn
);

   if (EntryStride_Gen % 4 != 0 || EntryStride_Gen < 28) begin : g_bad_stride
      $error("EntryStride_Gen must be a multiple of 4 and at least 28");
   end
   if (MaxEntries_Gen < 1 || MaxEntries_Gen > 4096) begin : g_bad_max
      $error("MaxEntries_Gen must lie in 1..4096");
   end
   if (ClockPeriod_Gen <= 0) begin : g_bad_period
      $error("ClockPeriod_Gen must be positive");
   end

   localparam logic [12:0] MAX_CNT  = 13'(MaxEntries_Gen);
   localparam logic [2:0]  LAST_WRD = 3'(WORDS_PER_ENTRY - 1);

   scan_state_e      state, state_nxt;
   core_list_entry_t entry;
   logic [12:0]      entry_idx, ent_sel, entry_count;
   logic [2:0]       word_idx, wrd_sel;
   logic [15:0]      addr;
   logic [31:0]      addr_calc;
   logic             addr_ovf;
   logic             go_addr, clr, set_err, latch, emit_fire;
   logic             done, err;
   logic             addr_req, data_req, addr_ack, data_ack, timeout;
   logic             resp_ok, term;

   assign addr_req = (state == ST_ADDR);
   assign data_req = (state == ST_DATA);
   assign resp_ok  = (AxiReadDataResponse_DatIn == AXI_RESP_OKAY);
   assign term     = (word_idx == 3'd0) && (AxiReadDataData_DatIn == 32'd0);

   core_list_axi_read_master #(
      .TimeoutCycles_Gen(TimeoutCycles_Gen)
   ) u_rd (
      .clk     (SysClk_ClkIn),
      .rst_n   (SysRstN_RstIn),
      .addr_req(addr_req),
      .data_req(data_req),
      .addr_ack(addr_ack),
      .data_ack(data_ack),
      .timeout (timeout),
      .ar_valid(AxiReadAddrValid_ValOut),
      .ar_ready(AxiReadAddrReady_RdyIn),
      .r_ready (AxiReadDataReady_RdyOut),
      .r_valid (AxiReadDataValid_ValIn)
   );

   // Scan state register
   always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
      if (!SysRstN_RstIn) state <= ST_IDLE;
      else                state <= state_nxt;
   end

   // Next-word address selection and scan sequencing
   always_comb begin
      state_nxt = state;
      go_addr   = 1'b0;
      clr       = 1'b0;
      set_err   = 1'b0;
      latch     = 1'b0;
      emit_fire = 1'b0;
      ent_sel   = entry_idx;
      wrd_sel   = word_idx + 3'd1;
      if (state == ST_IDLE) begin
         ent_sel = '0;
         wrd_sel = '0;
      end else if (state == ST_EMIT) begin
         ent_sel = entry_idx + 13'd1;
         wrd_sel = '0;
      end
      addr_calc = 32'(BaseAddr_Gen)
                + 32'(ent_sel) * 32'(EntryStride_Gen)
                + 32'(wrd_sel) * 32'd4;
      addr_ovf  = |addr_calc[31:16];
      unique case (state)
         ST_IDLE: begin
            if (Start_EvtIn) begin
               clr = 1'b1;
               if (addr_ovf) begin
                  set_err   = 1'b1;
                  state_nxt = ST_DONE;
               end else begin
                  go_addr   = 1'b1;
                  state_nxt = ST_ADDR;
               end
            end
         end
         ST_ADDR: begin
            if (timeout) begin
               set_err   = 1'b1;
               state_nxt = ST_DONE;
            end else if (addr_ack) begin
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (timeout) begin
               set_err   = 1'b1;
               state_nxt = ST_DONE;
            end else if (data_ack) begin
               latch = 1'b1;
               if (!resp_ok) begin
                  set_err   = 1'b1;
                  state_nxt = ST_DONE;
               end else if (term) begin
                  state_nxt = ST_DONE;
               end else if (word_idx == LAST_WRD) begin
                  state_nxt = ST_EMIT;
               end else if (addr_ovf) begin
                  set_err   = 1'b1;
                  state_nxt = ST_DONE;
               end else begin
                  go_addr   = 1'b1;
                  state_nxt = ST_ADDR;
               end
            end
         end
         ST_EMIT: begin
            if (EntryReady_RdyIn) begin
               emit_fire = 1'b1;
               if (entry_count + 13'd1 == MAX_CNT) begin
                  state_nxt = ST_DONE;
               end else if (addr_ovf) begin
                  set_err   = 1'b1;
                  state_nxt = ST_DONE;
               end else begin
                  go_addr   = 1'b1;
                  state_nxt = ST_ADDR;
               end
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Scan datapath: indices, address, entry words and sticky status
   always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
      if (!SysRstN_RstIn) begin
         entry_idx   <= '0;
         word_idx    <= '0;
         addr        <= '0;
         entry       <= '0;
         entry_count <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         if (clr) begin
            entry_count <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
         end
         if (go_addr) begin
            entry_idx <= ent_sel;
            word_idx  <= wrd_sel;
            addr      <= addr_calc[15:0];
         end
         if (latch) entry <= entry_set_word(entry, word_idx, AxiReadDataData_DatIn);
         if (emit_fire) entry_count <= entry_count + 13'd1;
         if (set_err) err <= 1'b1;
         if (state_nxt == ST_DONE && state != ST_DONE) done <= 1'b1;
      end
   end

   assign Busy_DatOut               = (state == ST_ADDR) || (state == ST_DATA) || (state == ST_EMIT);
   assign Done_DatOut               = done;
   assign Error_DatOut              = err;
   assign EntryCount_DatOut         = entry_count;
   assign EntryValid_ValOut         = (state == ST_EMIT);
   assign EntryTypeNr_DatOut        = entry.type_nr;
   assign EntryInstNr_DatOut        = entry.inst_nr;
   assign EntryVersion_DatOut       = entry.version;
   assign EntryAddrLow_DatOut       = entry.addr_low;
   assign EntryAddrHigh_DatOut      = entry.addr_high;
   assign EntryIrqMask_DatOut       = entry.irq_mask;
   assign EntrySensitivity_DatOut   = entry.sensitivity;
   assign AxiReadAddrAddress_AdrOut = addr;
   assign AxiReadAddrProt_DatOut    = 3'b000;

endmodule

// File: tb/tb_core_list_scanner.sv
// Randomized scoreboard bench for core_list_scanner.
// A list-level model predicts entries, final status and AR traffic.
module tb_core_list_scanner;

   localparam int MAXE = 4;
   localparam int TMO  = 16;

   logic        clk = 1'b0;
   logic        rst_n, start, busy, done, error;
   logic [12:0] entry_count;
   logic        entry_valid, entry_ready;
   logic [31:0] e_type, e_inst, e_ver, e_lo, e_hi, e_irq, e_sens;
   logic        ar_valid, ar_ready;
   logic [15:0] ar_addr;
   logic [2:0]  ar_prot;
   logic        r_valid, r_ready;
   logic [1:0]  r_resp;
   logic [31:0] r_data;

   core_list_scanner #(
      .BaseAddr_Gen(16'h0000), .EntryStride_Gen(64), .MaxEntries_Gen(MAXE),
      .TimeoutCycles_Gen(TMO), .ClockPeriod_Gen(20)
   ) dut (
      .SysClk_ClkIn(clk), .SysRstN_RstIn(rst_n), .Start_EvtIn(start),
      .Busy_DatOut(busy), .Done_DatOut(done), .Error_DatOut(error),
      .EntryCount_DatOut(entry_count), .EntryValid_ValOut(entry_valid),
      .EntryReady_RdyIn(entry_ready), .EntryTypeNr_DatOut(e_type),
      .EntryInstNr_DatOut(e_inst), .EntryVersion_DatOut(e_ver),
      .EntryAddrLow_DatOut(e_lo), .EntryAddrHigh_DatOut(e_hi),
      .EntryIrqMask_DatOut(e_irq), .EntrySensitivity_DatOut(e_sens),
      .AxiReadAddrValid_ValOut(ar_valid), .AxiReadAddrReady_RdyIn(ar_ready),
      .AxiReadAddrAddress_AdrOut(ar_addr), .AxiReadAddrProt_DatOut(ar_prot),
      .AxiReadDataValid_ValIn(r_valid), .AxiReadDataReady_RdyOut(r_ready),
      .AxiReadDataResponse_DatIn(r_resp), .AxiReadDataData_DatIn(r_data)
   );

   always #10 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [31:0]  words[8][7];
   int           n_ent = 0;
   int           err_addr = -1;
   bit           stall_ar = 0;
   bit           ar_rand = 0;
   bit           rdy_rand = 0;
   int           max_lat = 0;
   logic [223:0] sb[$];
   int           ar_hs = 0;
   int           arv_cycles = 0;
   logic [15:0]  first_ar = '0;
   logic [15:0]  last_ar = '0;
   int           entries_seen = 0;
   int           stall_entry = -1;
   int           stall_len = 0;
   int           stall_cnt = 0;
   int           stall_seen = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rd_word(input int a);
      int e, w;
      e = a / 64;
      w = (a % 64) / 4;
      if (e < n_ent && w < 7) return words[e][w];
      if (e == n_ent && w == 0) return 32'd0;
      return 32'hDEAD_0000 | 32'(a);
   endfunction

   // AXI slave: random AR acceptance and random read latency
   initial begin
      bit          arf, rf, have;
      logic [15:0] a_s, raddr;
      int          lat;
      ar_ready = 0; r_valid = 0; r_resp = 0; r_data = 0;
      have = 0; lat = 0; raddr = '0;
      forever begin
         @(negedge clk);
         arf = ar_valid && ar_ready;
         rf  = r_valid && r_ready;
         a_s = ar_addr;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            have = 0; r_valid = 0; ar_ready = 0;
         end else begin
            if (rf) r_valid = 0;
            if (arf) begin
               have = 1; raddr = a_s; ar_ready = 0;
               lat = $urandom_range(0, max_lat);
            end
            if (have) begin
               if (lat == 0) begin
                  r_valid = 1;
                  r_data  = rd_word(int'(raddr));
                  r_resp  = (int'(raddr) == err_addr) ? 2'b10 : 2'b00;
                  have    = 0;
               end else lat--;
            end
            if (!have && !r_valid)
               ar_ready = stall_ar ? 1'b0 : (ar_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
         end
      end
   end

   // Entry consumer: optional forced stall on one entry
   initial begin
      entry_ready = 0;
      forever begin
         @(posedge clk);
         #1;
         if (entry_valid && entries_seen == stall_entry && stall_cnt < stall_len) begin
            entry_ready = 0;
            stall_cnt++;
         end else begin
            entry_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
      end
   end

   // Monitor: scoreboard pops on entry handshakes, AR bookkeeping
   initial begin
      logic [223:0] cur, hold, exp;
      bit           hold_v;
      hold_v = 0; hold = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            cur = {e_type, e_inst, e_ver, e_lo, e_hi, e_irq, e_sens};
            if (ar_valid || r_ready) check("ar_r_exclusive", ar_valid & r_ready, 0);
            if (ar_valid) arv_cycles++;
            if (ar_valid && ar_ready) begin
               if (ar_hs == 0) first_ar = ar_addr;
               last_ar = ar_addr;
               ar_hs++;
            end
            if (entry_valid) check("no_ar_in_emit", ar_valid, 0);
            if (entry_valid && !entry_ready) begin
               if (hold_v) check("entry_hold", cur, hold);
               hold_v = 1;
               hold   = cur;
               if (entries_seen == stall_entry) stall_seen++;
            end else begin
               hold_v = 0;
            end
            if (entry_valid && entry_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_entry", 1, 0);
               end else begin
                  exp = sb.pop_front();
                  check("entry_words", cur, exp);
               end
               entries_seen++;
            end
         end else begin
            hold_v = 0;
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1;
      @(posedge clk);
      #1 start = 0;
   endtask

   task automatic build_list(input int n, input int eaddr);
      n_ent = n;
      err_addr = eaddr;
      for (int e = 0; e < 8; e++)
         for (int w = 0; w < 7; w++) begin
            words[e][w] = $urandom;
            if (w == 0 && words[e][w] == 0) words[e][w] = 32'd1;
         end
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      while (!done && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_done_reached"}, done, 1);
   endtask

   task automatic run_scan(input string tag, input int n, input int eaddr, input bit mid_start);
      int  exp_cnt, exp_ar, a, last;
      bit  stop, exp_err;
      build_list(n, eaddr);
      sb.delete();
      exp_cnt = 0; exp_ar = 0; exp_err = 0; stop = 0; last = 0;
      for (int e = 0; e < MAXE && !stop; e++) begin
         for (int w = 0; w < 7; w++) begin
            a = e * 64 + w * 4;
            exp_ar++;
            last = a;
            if (a == eaddr) begin exp_err = 1; stop = 1; break; end
            if (w == 0 && rd_word(a) == 0) begin stop = 1; break; end
         end
         if (!stop) begin
            sb.push_back({words[e][0], words[e][1], words[e][2], words[e][3],
                          words[e][4], words[e][5], words[e][6]});
            exp_cnt++;
         end
      end
      ar_hs = 0; arv_cycles = 0; entries_seen = 0; stall_cnt = 0; stall_seen = 0;
      pulse_start();
      @(negedge clk);
      check({tag, "_busy_after_start"}, {busy, done, error, entry_count}, {1'b1, 1'b0, 1'b0, 13'd0});
      check({tag, "_first_arvalid"}, ar_valid, 1);
      if (mid_start) begin
         repeat (5) @(negedge clk);
         check({tag, "_busy_mid"}, busy, 1);
         pulse_start();
      end
      wait_done(tag);
      check({tag, "_status"}, {busy, error, entry_count}, {1'b0, exp_err, 13'(exp_cnt)});
      check({tag, "_ar_count"}, ar_hs, exp_ar);
      check({tag, "_ar_first_last"}, {first_ar, last_ar}, {16'h0000, 16'(last)});
      check({tag, "_sb_empty"}, sb.size(), 0);
      @(negedge clk);
      check({tag, "_done_sticky"}, {busy, done, error}, {1'b0, 1'b1, exp_err});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctrl"},
            {busy, done, error, entry_count, entry_valid, ar_valid, ar_addr, ar_prot, r_ready}, 0);
      check({tag, "_data"}, {e_type, e_inst, e_ver, e_lo, e_hi, e_irq, e_sens}, 0);
   endtask

   initial begin
      int k;
      rst_n = 0;
      start = 0;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1;

      run_scan("t1", 3, -1, 0);

      stall_entry = 1;
      stall_len = 50;
      run_scan("t2", 3, -1, 0);
      check("t2_stall_cycles", stall_seen, 50);
      stall_entry = -1;

      ar_rand = 1; rdy_rand = 1; max_lat = 3;
      run_scan("t3", 3, 32'h48, 0);

      for (int i = 0; i < 5; i++)
         run_scan("rnd", $urandom_range(0, 6),
                  ($urandom_range(0, 1) != 0) ? 4 * $urandom_range(0, 40) : -1, 0);

      run_scan("t5", 5, -1, 1);

      stall_ar = 1;
      repeat (3) @(negedge clk);
      build_list(3, -1);
      arv_cycles = 0; ar_hs = 0;
      pulse_start();
      wait_done("t4");
      check("t4_status", {busy, error, entry_count}, {1'b0, 1'b1, 13'd0});
      check("t4_arvalid_cycles", arv_cycles, TMO);
      check("t4_no_handshake", ar_hs, 0);
      stall_ar = 0;

      run_scan("after_t4", 2, -1, 0);

      build_list(3, -1);
      pulse_start();
      k = 0;
      while (!(r_ready && ar_hs >= 9) && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check("t6_reached_data", r_ready, 1);
      #2 rst_n = 0;
      #1 check_reset_outputs("t6_reset");
      sb.delete();
      repeat (3) @(negedge clk);
      rst_n = 1;
      run_scan("t6_restart", 3, -1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
